// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: port numbering, FSM states and helpers shared
// by the memory arbiter and its priority picker.
package mips_mem_pkg;

  localparam int NPORT    = 3;
  localparam int DW       = 32;
  localparam int PORT_IF  = 0;
  localparam int PORT_MEM = 1;
  localparam int PORT_LD  = 2;
  localparam int CW       = 3;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  function automatic logic [1:0] port_idx(
    input logic [NPORT-1:0] oh
  );
    logic [1:0] idx;
    idx = '0;
    unique case (1'b1)
      oh[PORT_IF]:  idx = 2'(PORT_IF);
      oh[PORT_MEM]: idx = 2'(PORT_MEM);
      oh[PORT_LD]:  idx = 2'(PORT_LD);
      default:      idx = '0;
    endcase
    return idx;
  endfunction

  function automatic logic [NPORT-1:0] port_oh(
    input logic [1:0] idx
  );
    logic [NPORT-1:0] one;
    one = NPORT'(1);
    return one << idx;
  endfunction

endpackage

// File: rtl/mips_mem_pick.sv
// mips_mem_pick: fixed-priority picker with an IF starvation
// override; returns a one-hot winner among eligible requests.
module mips_mem_pick
  import mips_mem_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] elig,
  input  logic             starve,
  output logic [NPORT-1:0] win
);

  logic [NPORT-1:0] cand;

  assign cand = req & elig;

  always_comb begin
    win = '0;
    if (starve && cand[PORT_IF]) begin
      win[PORT_IF] = 1'b1;
    end else if (cand[PORT_MEM]) begin
      win[PORT_MEM] = 1'b1;
    end else if (cand[PORT_IF]) begin
      win[PORT_IF] = 1'b1;
    end else if (cand[PORT_LD]) begin
      win[PORT_LD] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: owns the shared word memory and serves IF,
// MEM-stage and loader ports one transaction at a time.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted_i,
  input  logic [2:0]        req_i,
  input  logic [2:0]        we_i,
  input  logic [3*AW-1:0]   addr_i,
  input  logic [95:0]       wdata_i,
  output logic [2:0]        gnt_o,
  output logic [2:0]        rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o
);

  logic [DW-1:0] mem [DEPTH];

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2:0]     starve_cnt;

  logic [1:0]     port_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;

  logic [2:0]     elig;
  logic [2:0]     we_eff;
  logic [2:0]     win;
  logic           starve;
  logic           done;
  logic           open;
  logic           accept;

  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_we;

  assign elig   = {halted_i, 2'b11};
  assign we_eff = we_i & 3'b110;
  assign starve = starve_cnt >= 3'(STARVE_LIMIT);

  // The final busy cycle also accepts, so the next
  // transaction overlaps the current response edge.
  assign done   = (state == ST_BUSY) && (cnt == '0);
  assign open   = (state == ST_IDLE) || done;

  mips_mem_pick u_pick (
    .req    (req_i),
    .elig   (elig),
    .starve (starve),
    .win    (win)
  );

  assign gnt_o  = (open && rst_n) ? win : 3'b000;
  assign accept = |gnt_o;
  assign busy_o = (state == ST_BUSY);

  always_comb begin
    sel_addr  = addr_i[PORT_IF*AW +: AW];
    sel_wdata = wdata_i[PORT_IF*DW +: DW];
    sel_we    = we_eff[PORT_IF];
    unique case (1'b1)
      win[PORT_MEM]: begin
        sel_addr  = addr_i[PORT_MEM*AW +: AW];
        sel_wdata = wdata_i[PORT_MEM*DW +: DW];
        sel_we    = we_eff[PORT_MEM];
      end
      win[PORT_LD]: begin
        sel_addr  = addr_i[PORT_LD*AW +: AW];
        sel_wdata = wdata_i[PORT_LD*DW +: DW];
        sel_we    = we_eff[PORT_LD];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_BUSY;
          cnt_nx   = CW'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (accept) begin
          cnt_nx = CW'(LATENCY - 1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      port_q  <= port_idx(gnt_o);
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!req_i[PORT_IF]) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (gnt_o[PORT_IF]) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 3'b111) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

  // Contents survive reset; a reset before the commit edge
  // drops the state to idle, so the write never happens.
  always_ff @(posedge clk1) begin
    if (done && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      if (done) begin
        rvalid_o <= port_oh(port_q);
        if (!we_q) begin
          rdata_o <= mem[addr_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: three arbiters (LATENCY 1..3) driven by
// directed and random requesters against a transaction model.
module tb_mips_mem_arbiter;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT = g + 1;

    logic        rst_n;
    logic        halted;
    logic [2:0]  req, we, gnt, rvalid;
    logic [29:0] addr;
    logic [95:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    mips_mem_arbiter #(
      .DEPTH(1024), .AW(10),
      .LATENCY(LAT), .STARVE_LIMIT(4)
    ) dut (
      .clk1     (clk1),
      .rst_n    (rst_n),
      .halted_i (halted),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .gnt_o    (gnt),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .busy_o   (busy)
    );

    function automatic string nm(input string s);
      return $sformatf("L%0d_%s", LAT, s);
    endfunction

    // Transaction-level reference: one job in flight that
    // finishes LAT edges after its accept edge.
    logic [31:0] mm [1024];
    bit          kn [1024];
    bit          m_busy;
    int          m_left, m_port, m_addr, m_starve;
    bit          m_we;
    logic [31:0] m_wdata;
    logic [2:0]  e_rv;
    logic [31:0] e_rd;
    bit          e_rd_ok;

    initial begin : model
      int          win;
      int          ord [3];
      logic [2:0]  el, exp_g, new_rv;
      m_busy = 0; m_starve = 0; e_rv = 0; e_rd = 0; e_rd_ok = 1;
      forever begin
        @(negedge clk1);
        if (rst_n !== 1'b1) begin
          m_busy = 0; m_starve = 0; e_rv = 0; e_rd = 0;
          check(nm("rst_gnt"), 32'(gnt), 32'h0);
          check(nm("rst_rvalid"), 32'(rvalid), 32'h0);
          check(nm("rst_rdata"), rdata, 32'h0);
          check(nm("rst_busy"), 32'(busy), 32'h0);
        end else begin
          el  = req & {halted, 2'b11};
          win = -1;
          if (m_starve >= 4) ord = '{0, 1, 2};
          else               ord = '{1, 0, 2};
          if (!m_busy || m_left == 1)
            for (int k = 0; k < 3; k++)
              if (win < 0 && el[ord[k]]) win = ord[k];
          exp_g = (win < 0) ? 3'b000 : (3'(1) << win);
          check(nm("m_gnt"), 32'(gnt), 32'(exp_g));
          check(nm("m_busy"), 32'(busy), 32'(m_busy));
          check(nm("m_rvalid"), 32'(rvalid), 32'(e_rv));
          if (e_rv != 0 && e_rd_ok)
            check(nm("m_rdata"), rdata, e_rd);
          new_rv = 3'b000;
          if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
              m_busy = 0;
              new_rv = 3'(1) << m_port;
              if (m_we) begin
                mm[m_addr] = m_wdata;
                kn[m_addr] = 1;
                e_rd_ok = 0;
              end else begin
                e_rd = mm[m_addr];
                e_rd_ok = kn[m_addr];
              end
            end
          end
          if (!req[0] || win == 0) m_starve = 0;
          else if (win > 0 && m_starve < 7) m_starve++;
          if (win >= 0) begin
            m_busy  = 1;
            m_left  = LAT;
            m_port  = win;
            m_we    = (win != 0) && we[win];
            m_addr  = int'(addr[win*10 +: 10]);
            m_wdata = wdata[win*32 +: 32];
          end
          e_rv = new_rv;
        end
      end
    end

    task automatic tick();
      @(posedge clk1);
      #1;
    endtask

    task automatic wait_rv(input int p);
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (!rvalid[p] && n < 20);
      check(nm("rv_latency"), 32'(n), 32'(LAT));
      check(nm("rv_port"), 32'(rvalid), 32'(3'(1) << p));
    endtask

    task automatic xfer(input int p, input bit w, input int a,
                        input logic [31:0] d,
                        output logic [31:0] rd);
      int n;
      req = 3'(1) << p;
      we  = w ? req : 3'b000;
      addr[p*10 +: 10]  = 10'(a);
      wdata[p*32 +: 32] = d;
      n = 0;
      #1;
      while (!gnt[p] && n < 50) begin
        tick();
        n++;
      end
      check(nm("xfer_gnt"), 32'(gnt[p]), 32'h1);
      tick();
      req = 3'b000;
      wait_rv(p);
      rd = rdata;
    endtask

    initial begin : stim
      logic [31:0] rd;
      logic [2:0]  seen;
      bit          g0, started;
      int          k, n, i, last;
      rst_n = 0; halted = 0; req = 0; we = 0;
      addr = '0; wdata = '0;
      repeat (3) tick();
      rst_n = 1;
      tick();
      check(nm("reset_busy"), 32'(busy), 32'h0);
      check(nm("reset_rvalid"), 32'(rvalid), 32'h0);

      // write then read back through the IF port
      xfer(1, 1, 5, 32'hDEAD_BEEF, rd);
      xfer(0, 1, 5, 32'h0BAD_F00D, rd);
      check(nm("t1_rvalid"), 32'(rvalid), 32'h1);
      check(nm("t1_rdata"), rd, 32'hDEAD_BEEF);

      // MEM traffic held: four MEM grants, then one IF grant
      req = 3'b011; we = 3'b000;
      addr[9:0] = 10'd1; addr[19:10] = 10'd2;
      k = 0;
      for (int c = 0; c < 12 * LAT + 20 && k < 10; c++) begin
        #1;
        if (gnt != 3'b000) begin
          check(nm("t2_seq"), 32'(gnt),
                (k % 5 == 4) ? 32'h1 : 32'h2);
          k++;
        end
        tick();
      end
      check(nm("t2_count"), 32'(k), 32'd10);
      req = 3'b000;
      repeat (LAT + 1) tick();

      // loader blocked until halted, then completes after it drops
      req = 3'b100; we = 3'b100;
      addr[29:20] = 10'd7; wdata[95:64] = 32'h5555_5555;
      for (int c = 0; c < 6; c++) begin
        #1;
        check(nm("t3_blocked"), 32'(gnt), 32'h0);
        tick();
      end
      halted = 1;
      #1;
      check(nm("t3_gnt"), 32'(gnt), 32'h4);
      tick();
      halted = 0; req = 3'b000;
      wait_rv(2);

      // reset right after a write is accepted drops that write
      xfer(1, 1, 9, 32'hAAAA_0009, rd);
      req = 3'b010; we = 3'b010;
      addr[19:10] = 10'd9; wdata[63:32] = 32'h0000_1234;
      #1;
      check(nm("t4_gnt"), 32'(gnt), 32'h2);
      tick();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1; req = 3'b000;
      for (int c = 0; c < LAT + 3; c++) begin
        #1;
        check(nm("t4_no_rv"), 32'(rvalid), 32'h0);
        tick();
      end
      xfer(0, 0, 9, 32'h0, rd);
      check(nm("t4_old"), rd, 32'hAAAA_0009);

      // IF withdraws before ever being granted
      req = 3'b011; we = 3'b000;
      addr[9:0] = 10'd3; addr[19:10] = 10'd4;
      #1;
      check(nm("t5_gnt"), 32'(gnt), 32'h2);
      tick();
      req = 3'b000;
      for (int c = 0; c < LAT + 3; c++) begin
        #1;
        check(nm("t5_no_gnt0"), 32'(gnt[0]), 32'h0);
        check(nm("t5_no_rv0"), 32'(rvalid[0]), 32'h0);
        tick();
      end

      // preload 0..15, then stream them back on the IF port
      halted = 1;
      for (int a = 0; a < 16; a++)
        xfer(2, 1, a, 32'hA000_0000 + 32'(a), rd);
      halted = 0;
      req = 3'b001; we = 3'b000; addr[9:0] = 10'd0;
      i = 0; n = 0; last = 0; started = 0;
      for (int c = 0; c < 40 * LAT + 40 && n < 16; c++) begin
        #1;
        if (rvalid[0]) begin
          check(nm("t6_data"), rdata, 32'hA000_0000 + 32'(n));
          if (n > 0)
            check(nm("t6_gap"), 32'(c - last), 32'(LAT));
          last = c;
          n++;
        end
        if (started && n < 16)
          check(nm("t6_busy"), 32'(busy), 32'h1);
        g0 = gnt[0];
        tick();
        if (g0) begin
          started = 1;
          i++;
          if (i < 16) addr[9:0] = 10'(i);
          else req = 3'b000;
        end
      end
      check(nm("t6_count"), 32'(n), 32'd16);
      repeat (LAT + 1) tick();

      // random requesters obeying the hold-until-grant rule
      for (int c = 0; c < 500; c++) begin
        @(negedge clk1);
        seen = gnt;
        @(posedge clk1);
        #1;
        for (int p = 0; p < 3; p++) begin
          if (seen[p] || !req[p]) begin
            if ($urandom_range(0, 3) != 0) begin
              req[p] = 1'b1;
              we[p]  = 1'($urandom_range(0, 1));
              addr[p*10 +: 10]  = 10'($urandom_range(0, 31));
              wdata[p*32 +: 32] = $urandom;
            end else begin
              req[p] = 1'b0;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            req[p] = 1'b0;
          end
        end
        if ($urandom_range(0, 9) == 0) halted = ~halted;
      end
      req = 3'b000;
      repeat (LAT + 2) tick();
      n_done++;
    end
  end

  initial begin : main
    for (int c = 0; c < 30000 && n_done < 3; c++)
      @(posedge clk1);
    if (n_done < 3) begin
      checks++;
      errors++;
      $display("FAIL timeout done=%0d want=3", n_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
